// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR arbiter and its round-robin selector.
package ddr_pkg;

    localparam int unsigned DDR_INDEX_W = 19;
    localparam int unsigned WORD_W      = 64;
    localparam int unsigned BURST_WORDS = 8;

    // Bit positions inside the one-hot grant vector.
    localparam int unsigned GNT_IFU = 0;
    localparam int unsigned GNT_LSU = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    // Latched DDR command, held on the DDR pins from ISSUE through WAIT.
    typedef struct packed {
        logic [DDR_INDEX_W-1:0] index;
        logic                   write;
        logic                   burst;
        logic [WORD_W-1:0]      wmask;
        logic [WORD_W-1:0]      wdata;
    } ddr_cmd_t;

endpackage

// File: rtl/ddr_arbiter_if.sv
// Requester-side bundle: IFU burst-read port and LSU single-word port.
interface ddr_arbiter_if #(
    parameter int unsigned INDEX_W     = 19,
    parameter int unsigned BURST_WORDS = 8
);
    localparam int unsigned LINE_W = 64 * BURST_WORDS;

    logic               ifu_req_valid;
    logic [INDEX_W-1:0] ifu_req_index;
    logic               ifu_req_ready;
    logic               ifu_resp_valid;
    logic [LINE_W-1:0]  ifu_resp_data;
    logic               ifu_flush;

    logic               lsu_req_valid;
    logic               lsu_req_write;
    logic [INDEX_W-1:0] lsu_req_index;
    logic [63:0]        lsu_req_wdata;
    logic [63:0]        lsu_req_wmask;
    logic               lsu_req_ready;
    logic               lsu_resp_valid;
    logic [63:0]        lsu_resp_data;

    // Requester side.
    modport master (
        output ifu_req_valid, ifu_req_index, ifu_flush,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_valid, lsu_req_write, lsu_req_index, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data
    );

    // Arbiter side.
    modport slave (
        input  ifu_req_valid, ifu_req_index, ifu_flush,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_valid, lsu_req_write, lsu_req_index, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data
    );
endinterface

// File: rtl/ddr_rr_sel.sv
// Two-way round-robin selector: on contention the requester not granted last wins.
module ddr_rr_sel
    import ddr_pkg::*;
(
    input  logic    req_ifu,
    input  logic    req_lsu,
    input  req_id_e last_grant,
    output logic [1:0] grant
);

    // One-hot grant from the two request bits and the last-grant history.
    always_comb begin
        grant = 2'b00;
        if (req_ifu && req_lsu) begin
            if (last_grant == REQ_IFU) begin
                grant[GNT_LSU] = 1'b1;
            end else begin
                grant[GNT_IFU] = 1'b1;
            end
        end else if (req_ifu) begin
            grant[GNT_IFU] = 1'b1;
        end else if (req_lsu) begin
            grant[GNT_LSU] = 1'b1;
        end
    end

endmodule

// File: rtl/ddr_arbiter.sv
// Arbitrates IFU burst reads and LSU single-word accesses onto one DDR port.
module ddr_arbiter
    import ddr_pkg::*;
#(
    parameter int unsigned INDEX_W     = 19,
    parameter int unsigned BURST_WORDS = ddr_pkg::BURST_WORDS
) (
    input  logic                   clock,
    input  logic                   reset,

    ddr_arbiter_if.slave           bus,

    output logic                   ddr_chip_enable,
    output logic [DDR_INDEX_W-1:0] ddr_index,
    output logic                   ddr_write_enable,
    output logic                   ddr_burst_mode,
    output logic [WORD_W-1:0]      ddr_opstore_write_mask,
    output logic [WORD_W-1:0]      ddr_opstore_write_data,

    input  logic [WORD_W-1:0]      ddr_opload_read_data,
    input  logic [WORD_W*BURST_WORDS-1:0] ddr_pc_read_inst,
    input  logic                   ddr_operation_done,
    input  logic                   ddr_ready
);

    localparam int unsigned LINE_W = WORD_W * BURST_WORDS;

    state_e            state_q, state_d;
    req_id_e           last_q, last_d;
    req_id_e           owner_q, owner_d;
    logic              drop_q, drop_d;
    ddr_cmd_t          cmd_q, cmd_d;
    logic              ce_q, ce_d;
    logic [LINE_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [WORD_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              ifu_rvalid_q, ifu_rvalid_d;
    logic              lsu_rvalid_q, lsu_rvalid_d;

    logic [INDEX_W-1:0] ifu_idx;
    logic [INDEX_W-1:0] lsu_idx;
    logic               ifu_cand;
    logic [1:0]         grant;
    logic               can_grant;
    logic               gnt_ifu;
    logic               gnt_lsu;
    logic               flush_hit;

    assign ifu_idx = bus.ifu_req_index;
    assign lsu_idx = bus.lsu_req_index;

    // A flush in IDLE removes the IFU from arbitration for that cycle.
    assign ifu_cand = bus.ifu_req_valid & ~bus.ifu_flush;

    ddr_rr_sel u_rr_sel (
        .req_ifu    (ifu_cand),
        .req_lsu    (bus.lsu_req_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    // Grants only happen in IDLE with the DDR free and reset released.
    assign can_grant = (state_q == ST_IDLE) & ddr_ready & ~reset;
    assign gnt_ifu   = can_grant & grant[GNT_IFU];
    assign gnt_lsu   = can_grant & grant[GNT_LSU];
    assign flush_hit = bus.ifu_flush & (owner_q == REQ_IFU);

    assign bus.ifu_req_ready  = gnt_ifu;
    assign bus.lsu_req_ready  = gnt_lsu;
    assign bus.ifu_resp_valid = ifu_rvalid_q & ~bus.ifu_flush;
    assign bus.ifu_resp_data  = ifu_rdata_q;
    assign bus.lsu_resp_valid = lsu_rvalid_q;
    assign bus.lsu_resp_data  = lsu_rdata_q;

    assign ddr_chip_enable        = ce_q;
    assign ddr_index              = cmd_q.index;
    assign ddr_write_enable       = cmd_q.write;
    assign ddr_burst_mode         = cmd_q.burst;
    assign ddr_opstore_write_mask = cmd_q.wmask;
    assign ddr_opstore_write_data = cmd_q.wdata;

    // Next-state, command latch and response capture.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        cmd_d        = cmd_q;
        ce_d         = 1'b0;
        ifu_rdata_d  = ifu_rdata_q;
        lsu_rdata_d  = lsu_rdata_q;
        ifu_rvalid_d = 1'b0;
        lsu_rvalid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_ifu) begin
                    owner_d     = REQ_IFU;
                    last_d      = REQ_IFU;
                    drop_d      = 1'b0;
                    cmd_d.index = DDR_INDEX_W'(ifu_idx);
                    cmd_d.write = 1'b0;
                    cmd_d.burst = 1'b1;
                    cmd_d.wmask = '0;
                    cmd_d.wdata = '0;
                    ce_d        = 1'b1;
                    state_d     = ST_ISSUE;
                end else if (gnt_lsu) begin
                    owner_d     = REQ_LSU;
                    last_d      = REQ_LSU;
                    drop_d      = 1'b0;
                    cmd_d.index = DDR_INDEX_W'(lsu_idx);
                    cmd_d.write = bus.lsu_req_write;
                    cmd_d.burst = 1'b0;
                    cmd_d.wmask = bus.lsu_req_wmask;
                    cmd_d.wdata = bus.lsu_req_wdata;
                    ce_d        = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (flush_hit) begin
                    drop_d = 1'b1;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush_hit) begin
                    drop_d = 1'b1;
                end
                if (ddr_operation_done) begin
                    state_d = ST_RESP;
                    if (owner_q == REQ_IFU) begin
                        ifu_rdata_d  = ddr_pc_read_inst;
                        ifu_rvalid_d = ~(drop_q | flush_hit);
                    end else begin
                        lsu_rdata_d  = cmd_q.write ? '0 : ddr_opload_read_data;
                        lsu_rvalid_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_q       <= REQ_IFU;
            owner_q      <= REQ_IFU;
            drop_q       <= 1'b0;
            cmd_q        <= '0;
            ce_q         <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            cmd_q        <= cmd_d;
            ce_q         <= ce_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Scoreboard bench for ddr_arbiter with a behavioural DDR model.
`timescale 1ns/1ps
module tb_ddr_arbiter;
    import ddr_pkg::*;

    localparam int unsigned INDEX_W = 19;
    localparam int unsigned LINE_W  = 512;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ddr_arbiter_if #(.INDEX_W(INDEX_W), .BURST_WORDS(8)) bus ();

    logic              ddr_chip_enable;
    logic [18:0]       ddr_index;
    logic              ddr_write_enable;
    logic              ddr_burst_mode;
    logic [63:0]       ddr_opstore_write_mask;
    logic [63:0]       ddr_opstore_write_data;
    logic [63:0]       ddr_opload_read_data = '0;
    logic [LINE_W-1:0] ddr_pc_read_inst = '0;
    logic              ddr_operation_done = 1'b0;
    logic              ddr_ready;

    ddr_arbiter #(.INDEX_W(INDEX_W), .BURST_WORDS(8)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .bus                    (bus),
        .ddr_chip_enable        (ddr_chip_enable),
        .ddr_index              (ddr_index),
        .ddr_write_enable       (ddr_write_enable),
        .ddr_burst_mode         (ddr_burst_mode),
        .ddr_opstore_write_mask (ddr_opstore_write_mask),
        .ddr_opstore_write_data (ddr_opstore_write_data),
        .ddr_opload_read_data   (ddr_opload_read_data),
        .ddr_pc_read_inst       (ddr_pc_read_inst),
        .ddr_operation_done     (ddr_operation_done),
        .ddr_ready              (ddr_ready)
    );

    // ---------------- DDR model ----------------
    logic [63:0] mem [int unsigned];
    logic        busy = 1'b0;
    logic [7:0]  cnt = '0;
    logic        m_write, m_burst;
    logic [18:0] m_idx;
    logic [63:0] m_wdata, m_wmask;

    assign ddr_ready = ~busy & ~ddr_operation_done;

    function automatic logic [63:0] rd(input int unsigned a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            busy               <= 1'b0;
            cnt                <= '0;
            ddr_operation_done <= 1'b0;
        end else begin
            ddr_operation_done <= 1'b0;
            if (busy) begin
                if (cnt == 8'd1) begin
                    busy               <= 1'b0;
                    ddr_operation_done <= 1'b1;
                    if (m_burst) begin
                        for (int i = 0; i < 8; i++)
                            ddr_pc_read_inst[i*64 +: 64] <= rd(32'(m_idx) + 32'(i));
                    end else if (m_write) begin
                        mem[32'(m_idx)] = (rd(32'(m_idx)) & ~m_wmask) | (m_wdata & m_wmask);
                    end else begin
                        ddr_opload_read_data <= rd(32'(m_idx));
                    end
                end
                cnt <= cnt - 8'd1;
            end else if (ddr_chip_enable) begin
                busy    <= 1'b1;
                cnt     <= ddr_burst_mode ? 8'd80 : 8'd20;
                m_write <= ddr_write_enable;
                m_burst <= ddr_burst_mode;
                m_idx   <= ddr_index;
                m_wdata <= ddr_opstore_write_data;
                m_wmask <= ddr_opstore_write_mask;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int n_ifu_resp = 0;
    int n_lsu_resp = 0;
    logic [LINE_W-1:0] exp_ifu_q [$];
    logic [63:0]       exp_lsu_q [$];
    req_id_e           exp_gnt_q [$];

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'h0101_0101_0101_0101 * 64'(i + 1);
    endfunction

    function automatic logic [LINE_W-1:0] exp_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = pat(i);
        return l;
    endfunction

    // Monitor: pops expected grants/responses whenever the DUT presents one.
    always @(negedge clock) begin : monitor
        req_id_e g;
        if (!reset) begin
            if (bus.ifu_req_ready || bus.lsu_req_ready) begin
                if (exp_gnt_q.size() == 0) begin
                    check("unexpected_grant", 512'({bus.ifu_req_ready, bus.lsu_req_ready}), 512'(0));
                end else begin
                    g = exp_gnt_q.pop_front();
                    check("grant_order", 512'({bus.ifu_req_ready, bus.lsu_req_ready}),
                          (g == REQ_IFU) ? 512'(2'b10) : 512'(2'b01));
                end
            end
            if (bus.ifu_resp_valid) begin
                n_ifu_resp++;
                if (exp_ifu_q.size() == 0) check("unexpected_ifu_resp", 512'(bus.ifu_resp_valid), 512'(0));
                else check("ifu_resp_data", bus.ifu_resp_data, exp_ifu_q.pop_front());
            end
            if (bus.lsu_resp_valid) begin
                n_lsu_resp++;
                if (exp_lsu_q.size() == 0) check("unexpected_lsu_resp", 512'(bus.lsu_resp_valid), 512'(0));
                else check("lsu_resp_data", 512'(bus.lsu_resp_data), 512'(exp_lsu_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic ifu_req(input logic [18:0] idx);
        int n = 0;
        bus.ifu_req_index = idx;
        bus.ifu_req_valid = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.ifu_req_ready && n < 1000);
        if (!bus.ifu_req_ready) check("ifu_req_timeout", 512'(bus.ifu_req_ready), 512'(1));
        @(posedge clock);
        #1;
        bus.ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_req(input logic wr, input logic [18:0] idx, input logic [63:0] wd, input logic [63:0] wm);
        int n = 0;
        bus.lsu_req_write = wr;
        bus.lsu_req_index = idx;
        bus.lsu_req_wdata = wd;
        bus.lsu_req_wmask = wm;
        bus.lsu_req_valid = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.lsu_req_ready && n < 1000);
        if (!bus.lsu_req_ready) check("lsu_req_timeout", 512'(bus.lsu_req_ready), 512'(1));
        @(posedge clock);
        #1;
        bus.lsu_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_ifu_q.size() + exp_lsu_q.size() + exp_gnt_q.size()) != 0 && n < 2000) begin
            @(posedge clock);
            n++;
        end
        check("drain_pending", 512'(exp_ifu_q.size() + exp_lsu_q.size() + exp_gnt_q.size()), 512'(0));
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_chip_enable"}, 512'(ddr_chip_enable), 512'(0));
        check({tag, "_ddr_index"},   512'(ddr_index), 512'(0));
        check({tag, "_write_en"},    512'(ddr_write_enable), 512'(0));
        check({tag, "_burst"},       512'(ddr_burst_mode), 512'(0));
        check({tag, "_wmask"},       512'(ddr_opstore_write_mask), 512'(0));
        check({tag, "_wdata"},       512'(ddr_opstore_write_data), 512'(0));
        check({tag, "_readies"},     512'({bus.ifu_req_ready, bus.lsu_req_ready}), 512'(0));
        check({tag, "_resp_valids"}, 512'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 512'(0));
        check({tag, "_ifu_data"},    bus.ifu_resp_data, 512'(0));
        check({tag, "_lsu_data"},    512'(bus.lsu_resp_data), 512'(0));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int c0;
        int n;
        reset = 1'b1;
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_index = '0;
        bus.ifu_flush     = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_write = 1'b0;
        bus.lsu_req_index = '0;
        bus.lsu_req_wdata = '0;
        bus.lsu_req_wmask = '0;
        for (int i = 0; i < 8; i++) mem[32'h100 + 32'(i)] = pat(i);

        // Both requesters valid out of reset: LSU, IFU, LSU.
        exp_gnt_q.push_back(REQ_LSU);
        exp_gnt_q.push_back(REQ_IFU);
        exp_gnt_q.push_back(REQ_LSU);
        exp_lsu_q.push_back(64'h0101_0101_0101_0101);
        exp_ifu_q.push_back(exp_line());
        exp_lsu_q.push_back(64'h0404_0404_0404_0404);
        fork
            begin
                lsu_req(1'b0, 19'h100, '0, '0);
                lsu_req(1'b0, 19'h103, '0, '0);
            end
            ifu_req(19'h100);
            begin
                repeat (2) @(posedge clock);
                #1;
                check_all_zero("reset");
                reset = 1'b0;
            end
        join
        drain();

        // Standalone IFU burst read.
        exp_gnt_q.push_back(REQ_IFU);
        exp_ifu_q.push_back(exp_line());
        ifu_req(19'h100);
        drain();

        // LSU write then read back; then a partial-mask write.
        exp_gnt_q.push_back(REQ_LSU);
        exp_lsu_q.push_back(64'h0);
        lsu_req(1'b1, 19'h20, 64'h0000_0000_DEAD_BEEF, '1);
        drain();
        exp_gnt_q.push_back(REQ_LSU);
        exp_lsu_q.push_back(64'h0000_0000_DEAD_BEEF);
        lsu_req(1'b0, 19'h20, '0, '0);
        drain();
        exp_gnt_q.push_back(REQ_LSU);
        exp_lsu_q.push_back(64'h0);
        lsu_req(1'b1, 19'h21, '1, 64'h0000_0000_FFFF_FFFF);
        drain();
        exp_gnt_q.push_back(REQ_LSU);
        exp_lsu_q.push_back(64'h0000_0000_FFFF_FFFF);
        lsu_req(1'b0, 19'h21, '0, '0);
        drain();

        // Flush in IDLE blocks the IFU for that cycle only.
        exp_gnt_q.push_back(REQ_IFU);
        exp_ifu_q.push_back(exp_line());
        bus.ifu_req_index = 19'h100;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_flush     = 1'b1;
        @(negedge clock);
        check("flush_blocks_grant", 512'(bus.ifu_req_ready), 512'(0));
        @(posedge clock);
        #1;
        bus.ifu_flush = 1'b0;
        @(negedge clock);
        check("grant_after_flush", 512'(bus.ifu_req_ready), 512'(1));
        @(posedge clock);
        #1;
        bus.ifu_req_valid = 1'b0;
        drain();

        // Flush 10 cycles into WAIT drops the IFU response; LSU follows normally.
        c0 = n_ifu_resp;
        exp_gnt_q.push_back(REQ_IFU);
        ifu_req(19'h100);
        repeat (11) @(posedge clock);
        #1;
        bus.ifu_flush = 1'b1;
        @(posedge clock);
        #1;
        bus.ifu_flush = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        check("flush_wait_no_resp", 512'(n_ifu_resp - c0), 512'(0));
        exp_gnt_q.push_back(REQ_LSU);
        exp_lsu_q.push_back(64'h0000_0000_DEAD_BEEF);
        lsu_req(1'b0, 19'h20, '0, '0);
        drain();

        // Flush during RESP masks that cycle's IFU response.
        c0 = n_ifu_resp;
        exp_gnt_q.push_back(REQ_IFU);
        ifu_req(19'h100);
        n = 0;
        while (!ddr_operation_done && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("done_seen", 512'(ddr_operation_done), 512'(1));
        @(posedge clock);
        #1;
        bus.ifu_flush = 1'b1;
        @(posedge clock);
        #1;
        bus.ifu_flush = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("flush_resp_no_resp", 512'(n_ifu_resp - c0), 512'(0));
        drain();

        // Reset during WAIT abandons the operation.
        c0 = n_ifu_resp + n_lsu_resp;
        exp_gnt_q.push_back(REQ_IFU);
        ifu_req(19'h100);
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_all_zero("reset_mid");
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (150) @(posedge clock);
        #1;
        check("reset_no_resp", 512'(n_ifu_resp + n_lsu_resp - c0), 512'(0));
        exp_gnt_q.push_back(REQ_LSU);
        exp_lsu_q.push_back(64'h0202_0202_0202_0202);
        lsu_req(1'b0, 19'h101, '0, '0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 The block SHALL have the parameter INDEX_W, default 19, giving the DDR index width in 64-bit words.
REQ-002 The block SHALL have the parameter BURST_WORDS, default 8, giving the number of 64-bit words per burst (512 bits total).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clock  in  1  sole clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Ports: ifu_req_valid in 1, ifu_req_index in INDEX_W, ifu_req_ready out 1  -- instruction burst-read request.
REQ-007 Ports: ifu_resp_valid out 1, ifu_resp_data out 512  -- instruction burst-read response.
REQ-008 Port: ifu_flush  in  1  cancels any pending or outstanding instruction request.
REQ-009 Ports: lsu_req_valid in 1, lsu_req_write in 1, lsu_req_index in INDEX_W, lsu_req_wdata in 64, lsu_req_wmask in 64, lsu_req_ready out 1  -- data single-word request.
REQ-010 Ports: lsu_resp_valid out 1, lsu_resp_data out 64  -- data single-word response.
REQ-011 Ports to DDR model: ddr_chip_enable out 1, ddr_index out 19, ddr_write_enable out 1, ddr_burst_mode out 1, ddr_opstore_write_mask out 64, ddr_opstore_write_data out 64.
REQ-012 Ports from DDR model: ddr_opload_read_data in 64, ddr_pc_read_inst in 512, ddr_operation_done in 1, ddr_ready in 1.

Function
REQ-013 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-014 In IDLE with ddr_ready=1 and at least one valid request, the block SHALL assert the winner's req_ready combinationally, latch its fields, and move to ISSUE.
REQ-015 Arbitration SHALL be round-robin on a last-grant bit: when both requesters are valid, the one not granted last wins; after reset the LSU has priority.
REQ-016 In ISSUE, ddr_chip_enable SHALL be 1 for exactly one cycle; the FSM then moves to WAIT.
REQ-017 From ISSUE until leaving WAIT, ddr_index, ddr_write_enable, ddr_burst_mode, the write mask and the write data SHALL be held at the latched values.
REQ-018 For IFU grants: burst_mode=1, write_enable=0. For LSU grants: burst_mode=0, write_enable=lsu_req_write.
REQ-019 In WAIT, on ddr_operation_done=1, the block SHALL capture ddr_pc_read_inst or ddr_opload_read_data into a response register and move to RESP.
REQ-020 In RESP, the block SHALL assert the owner's resp_valid for exactly one cycle, then return to IDLE; there is no back-to-back grant in RESP.
REQ-021 An LSU write SHALL also produce lsu_resp_valid, with lsu_resp_data=0.
REQ-022 No req_ready SHALL be asserted outside IDLE; requesters hold their request stable until ready is seen.
REQ-023 ifu_flush in IDLE SHALL block an IFU grant that cycle; the LSU may still be granted.
REQ-024 ifu_flush while an IFU operation is in ISSUE or WAIT SHALL set a drop flag: the DDR operation completes, RESP still lasts one cycle, and ifu_resp_valid stays 0.
REQ-025 ifu_flush in RESP SHALL suppress that cycle's ifu_resp_valid.
REQ-026 ddr_index SHALL be the request index truncated or zero-extended to 19 bits.
REQ-027 Address alignment is the requester's responsibility.

Reset
REQ-028 Reset SHALL force the FSM to IDLE, clear the last-grant bit (LSU priority), and clear the drop flag.
REQ-029 Reset SHALL drive all ready, valid and ddr_* outputs to 0 and clear both response data registers to 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no response; the DDR model is reset concurrently.

Structure
REQ-031 The state encoding, the requester-ID enum and BURST_WORDS SHALL live in the shared package ddr_pkg.
REQ-032 The round-robin selector SHALL be the sub-module ddr_rr_sel: two request bits plus the last-grant bit in, one-hot grant out.

Verification
REQ-033 IFU burst read at index 0x100, memory preloaded with words 0..7 -> ifu_resp_data = {w7..w0}, exactly one ifu_resp_valid, ~80+ cycles after grant.
REQ-034 LSU write at index 0x20, data 0xDEADBEEF, full mask, then LSU read of 0x20 -> lsu_resp_data = 0xDEADBEEF.
REQ-035 Both requesters valid from reset -> LSU granted first, IFU second, LSU third (alternation).
REQ-036 ifu_flush pulsed 10 cycles into WAIT of an IFU read -> no ifu_resp_valid; a following LSU read completes normally.
REQ-037 ifu_flush and ifu_req_valid high together in IDLE with the LSU idle -> no grant that cycle; the IFU is granted the next cycle after the flush drops.
REQ-038 Reset asserted during WAIT -> all outputs 0 the next cycle and no resp_valid ever pulses for the abandoned operation.
